// File: rtl/inverse_sched.sv
// rtl/inverse_sched.sv - round-robin scheduler sharing one 2x2 inverse_matrix unit between N_REQ requesters
// Optional macro SINGULAR_CHECK_EN: reject singular matrices (det == 0 or a0 == 0) without issuing them.
module inverse_sched #(
  parameter int N_REQ   = 2,
  parameter int INV_LAT = 1,
  parameter int W       = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*4*W-1:0] req_data,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [4*W-1:0]       rsp_data,
  output logic                 rsp_err,
  output logic                 inv_en,
  output logic [W-1:0]         inv_inp_0,
  output logic [W-1:0]         inv_inp_1,
  output logic [W-1:0]         inv_inp_2,
  output logic [W-1:0]         inv_inp_3,
  input  logic [W-1:0]         inv_res_0,
  input  logic [W-1:0]         inv_res_1,
  input  logic [W-1:0]         inv_res_2,
  input  logic [W-1:0]         inv_res_3,
  output logic                 busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  rr_q, rr_d;
  logic [PW-1:0]  gnt_q, gnt_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [4*W-1:0] op_q, op_d;
  logic [4*W-1:0] res_q, res_d;

  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] gnt_oh;
  logic [PW-1:0]    off;
  logic [PW-1:0]    gnt_idx;
  logic [PW:0]      sum;
  logic             found;
  logic [4*W-1:0]   sel_data;
  logic             accept;
  logic             rsp_fire;
  logic             singular;

  // Rotate the request vector so bit 0 is the requester at rr_q, then take the lowest set bit.
  always_comb begin
    rot   = N_REQ'({req_valid, req_valid} >> rr_q);
    found = 1'b0;
    off   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = PW'(i);
      end
    end
    sum = {1'b0, rr_q} + {1'b0, off};
    if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
    gnt_idx  = PW'(sum);
    sel_data = '0;
    gnt_oh   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_oh[i] = (PW'(i) == gnt_idx);
      if (PW'(i) == gnt_idx) sel_data = req_data[i*4*W +: 4*W];
    end
  end

  // Gated by reset so req_ready stays low while reset is held.
  assign req_ready = (state_q == S_IDLE && reset && found) ? gnt_oh : '0;
  assign accept    = |req_ready;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = (state_q == S_RESP) && (PW'(i) == gnt_q);
    end
  end

  assign rsp_fire = |(rsp_valid & rsp_ready);

`ifdef SINGULAR_CHECK_EN
  logic [W-1:0]          a0, a1, a2, a3;
  logic signed [2*W-1:0] det;
  logic                  err_q;

  assign a0 = op_q[W-1:0];
  assign a1 = op_q[2*W-1:W];
  assign a2 = op_q[3*W-1:2*W];
  assign a3 = op_q[4*W-1:3*W];

  always_comb begin
    det = $signed({{W{a0[W-1]}}, a0}) * $signed({{W{a3[W-1]}}, a3})
        - $signed({{W{a1[W-1]}}, a1}) * $signed({{W{a2[W-1]}}, a2});
  end

  // a0 == 0 is rejected too because the shared unit divides by a0 first.
  assign singular = (state_q == S_BUSY) && (cnt_q == 4'd0) && ((det == '0) || (a0 == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (state_q == S_BUSY && (singular || cnt_q == 4'(INV_LAT))) begin
      err_q <= singular;
    end
  end

  assign rsp_err = err_q;
`else
  assign singular = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = sel_data;
          gnt_d   = gnt_idx;
          rr_d    = (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 4'd1;
        if (singular) begin
          res_d   = '0;
          state_d = S_RESP;
        end else if (cnt_q == 4'(INV_LAT)) begin
          res_d   = {inv_res_3, inv_res_2, inv_res_1, inv_res_0};
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign inv_en    = (state_q == S_BUSY) && !singular;
  assign inv_inp_0 = op_q[W-1:0];
  assign inv_inp_1 = op_q[2*W-1:W];
  assign inv_inp_2 = op_q[3*W-1:2*W];
  assign inv_inp_3 = op_q[4*W-1:3*W];
  assign rsp_data  = res_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/inverse_sched.md
# inverse_sched

Round-robin scheduler that shares one 2x2 `inverse_matrix` instance between `N_REQ` requesters in the PCA precoder datapath.
- Accepts a 4-word matrix from a requester over a valid/ready handshake.
- Sequences the shared unit's enable and operand inputs, then captures the four result words after a fixed latency.
- Returns the result to the same requester over a valid/ready response channel.
- Only one matrix is in flight at a time.

## Interface

Parameters:
- `N_REQ`, 2: number of requesters, 2..8.
- `INV_LAT`, 1: cycles from the first enabled cycle of the shared unit until its outputs are valid, 1..15.
- `W`, 64: width of each matrix word.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, `N_REQ`: request pending, one bit per requester.
- `req_ready`, output, `N_REQ`: one-hot accept.
- `req_data`, input, `N_REQ*4*W`: matrix {a3,a2,a1,a0} for requester k, in slice [k*4W +: 4W].
- `rsp_valid`, output, `N_REQ`: one-hot result available.
- `rsp_ready`, input, `N_REQ`: requester consumes the result.
- `rsp_data`, output, `4*W`: result {i3,i2,i1,i0}.
- `rsp_err`, output, 1: result is invalid because the matrix is singular. Tied to 0 when `SINGULAR_CHECK_EN` is undefined.
- `inv_en`, output, 1: drives the shared unit's enable.
- `inv_inp_0`..`inv_inp_3`, output, `W` each: operands driven to the shared unit.
- `inv_res_0`..`inv_res_3`, input, `W` each: results returned by the shared unit.
- `busy`, output, 1: high in any state other than IDLE.

## Operation

State machine: IDLE, BUSY, RESP.

IDLE
- Grant goes to the first set `req_valid` bit at or after pointer `rr_ptr`, wrapping around.
- `req_ready[g]` is combinational and is high only in IDLE.
- Handshake edge: operands are registered, `g` is stored, `rr_ptr` becomes (g+1) mod `N_REQ`, the counter is cleared, and the state moves to BUSY.
- If no `req_valid` bit is set, the state stays IDLE and `req_ready` is 0.

BUSY
- `inv_en` is 1 and `inv_inp_*` hold the registered operands.
- The counter increments every cycle.
- On the edge where counter == `INV_LAT`, `inv_res_*` are captured into `rsp_data` and the state moves to RESP.

RESP
- `rsp_valid[g]` is 1 and `inv_en` is 0.
- `rsp_data` and `rsp_err` are held stable until `rsp_ready[g]` is seen, then the state returns to IDLE.
- Other requesters' `rsp_ready` bits are ignored.

General rules
- No new request is accepted in BUSY or RESP; `req_ready` is all-zero there.
- Outside BUSY, `inv_inp_*` hold their last values.
- A `req_valid` bit that drops before its grant is legal; it is simply not served.
- Simultaneous `req_valid` bits are resolved strictly by `rr_ptr`, so no requester waits more than `N_REQ-1` grants.
- Arithmetic is pass-through; the block does not modify data.

## Timing

- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `inv_en`=0, `inv_inp_*`=0, `busy`=0, `rr_ptr`=0, state=IDLE.
- Reset asserted mid-operation: all outputs go immediately (asynchronously) to their reset values. The in-flight matrix is dropped, with no response.
- Handshake accepted in cycle 0:
  - `inv_en` is high in cycles 1..`INV_LAT`+1.
  - `rsp_valid` rises in cycle `INV_LAT`+2 (cycle 3 by default).
- `rsp_ready` already high when `rsp_valid` rises: one RESP cycle, IDLE in the next cycle.
- Back-to-back throughput: one matrix per `INV_LAT`+3 cycles.

## Configuration

`SINGULAR_CHECK_EN`
- Defined:
  - In the first BUSY cycle, compute a0*a3 - a1*a2 at full 2W-bit signed width. Also check a0 == 0, since the shared unit divides by a0 first.
  - If either condition is true, `inv_en` is forced to 0 for that cycle and the state goes directly to RESP with `rsp_data`=0 and `rsp_err`=1. Response latency is then 2 cycles after the accept.
  - Otherwise `rsp_err`=0 and the normal flow applies.
- Undefined: no check logic is built, `rsp_err` is constant 0, and every matrix is issued.

## Test plan

- Reset/idle:
  - Stimulus: hold `reset`=0, then release.
  - Required: all outputs 0. With no requests, `busy` stays 0 and `inv_en` stays 0.
- Single request:
  - Stimulus: requester 0 sends {1,0,0,2}; the unit model returns {1,0,0,1} after `INV_LAT`=1.
  - Required: `req_ready[0]` high in cycle 0, `inv_en` high in cycles 1-2, `rsp_valid[0]` high in cycle 3 with `rsp_data`={1,0,0,1}.
- Contention (`N_REQ`=2):
  - Stimulus: both `req_valid` bits held high for 4 transactions.
  - Required: grants alternate 0,1,0,1.
- Response backpressure:
  - Stimulus: hold `rsp_ready` low for 5 cycles.
  - Required: `rsp_valid` and `rsp_data` stable and `req_ready`=0 throughout. IDLE in the cycle after `rsp_ready` rises.
- Reset during BUSY:
  - Stimulus: assert `reset` in cycle 1.
  - Required: `inv_en` drops to 0 immediately and no `rsp_valid` follows.
- With `SINGULAR_CHECK_EN`:
  - Stimulus: send matrix {a3=4,a2=2,a1=2,a0=1}, which has determinant 0.
  - Required: `inv_en` never rises, `rsp_valid` rises in cycle 2 with `rsp_err`=1 and `rsp_data`=0.
